// File: rtl/register_file_if.sv
// Register-file bus bundle: data/address read and write ports, inc/dec control,
// and the wrap/err status. The master drives requests and the slave (the
// register file) drives the read buses and the status flags.
interface register_file_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 2
);
  logic             rdata;
  logic [SEL_W-1:0] rdata_sel;
  wire  [WIDTH-1:0] out_data;

  logic             raddr;
  logic [SEL_W-1:0] raddr_sel;
  wire  [WIDTH-1:0] out_addr;

  logic             wdata;
  logic [SEL_W-1:0] wdata_sel;
  logic [WIDTH-1:0] in_data;

  logic             waddr;
  logic [SEL_W-1:0] waddr_sel;
  logic [WIDTH-1:0] in_addr;

  logic             inc;
  logic             dec;
  logic [SEL_W-1:0] incdec_sel;

  logic             clr_err;
  logic             wrap;
  logic             err;

  modport master (
    output rdata, rdata_sel, raddr, raddr_sel,
    output wdata, wdata_sel, in_data, waddr, waddr_sel, in_addr,
    output inc, dec, incdec_sel, clr_err,
    input  out_data, out_addr, wrap, err
  );

  modport slave (
    input  rdata, rdata_sel, raddr, raddr_sel,
    input  wdata, wdata_sel, in_data, waddr, waddr_sel, in_addr,
    input  inc, dec, incdec_sel, clr_err,
    output out_data, out_addr, wrap, err
  );
endinterface

// File: rtl/register_file.sv
// Dual-read, dual-write register file with per-register inc/dec, a wrap pulse
// and a sticky write-conflict flag. Read buses float when not enabled.
// Optional same-cycle write-to-read forwarding is enabled by defining
// REGFILE_BYPASS_EN; by default reads return the stored value only.
module register_file #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEL_W = 2
) (
  input logic clk,
  input logic rst_n,
  register_file_if.slave bus
);

  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

  logic [WIDTH-1:0] regs      [DEPTH];
  logic [WIDTH-1:0] regs_next [DEPTH];
  logic             wrap_q;
  logic             err_q;
  logic             wrap_next;
  logic             err_next;

  logic             conflict;
  logic             wdata_ok;
  logic             waddr_ok;
  logic             incdec_go;
  logic [WIDTH-1:0] incdec_val;
  logic [WIDTH-1:0] rd_data_val;
  logic [WIDTH-1:0] rd_addr_val;

  // Decode the write/inc/dec requests for this cycle.
  always_comb begin
    conflict   = bus.wdata && bus.waddr && (bus.wdata_sel == bus.waddr_sel);
    wdata_ok   = bus.wdata && !conflict;
    waddr_ok   = bus.waddr && !conflict;
    incdec_val = regs[bus.incdec_sel];
    // Any write aimed at the inc/dec target (even a conflicting one) drops it.
    incdec_go  = (bus.inc ^ bus.dec)
                 && !(bus.wdata && (bus.wdata_sel == bus.incdec_sel))
                 && !(bus.waddr && (bus.waddr_sel == bus.incdec_sel));
    wrap_next  = incdec_go && ((bus.inc && (incdec_val == AllOnes)) ||
                               (bus.dec && (incdec_val == '0)));
    // Set wins over clear.
    err_next   = conflict ? 1'b1 : (bus.clr_err ? 1'b0 : err_q);
  end

  // Next-state value for every register.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_next[i] = regs[i];
      if (incdec_go && (int'(bus.incdec_sel) == i)) begin
        regs_next[i] = bus.inc ? regs[i] + 1'b1 : regs[i] - 1'b1;
      end
      if (wdata_ok && (int'(bus.wdata_sel) == i)) begin
        regs_next[i] = bus.in_data;
      end
      if (waddr_ok && (int'(bus.waddr_sel) == i)) begin
        regs_next[i] = bus.in_addr;
      end
    end
  end

  // Register array and status flags, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= regs_next[i];
      end
      wrap_q <= wrap_next;
      err_q  <= err_next;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read muxes with forwarding of this cycle's non-conflicting writes.
  always_comb begin
    rd_data_val = regs[bus.rdata_sel];
    rd_addr_val = regs[bus.raddr_sel];
    if (rst_n) begin
      if (wdata_ok && (bus.wdata_sel == bus.rdata_sel)) begin
        rd_data_val = bus.in_data;
      end else if (waddr_ok && (bus.waddr_sel == bus.rdata_sel)) begin
        rd_data_val = bus.in_addr;
      end
      if (wdata_ok && (bus.wdata_sel == bus.raddr_sel)) begin
        rd_addr_val = bus.in_data;
      end else if (waddr_ok && (bus.waddr_sel == bus.raddr_sel)) begin
        rd_addr_val = bus.in_addr;
      end
    end
  end
`else
  // Read muxes returning the stored value only.
  always_comb begin
    rd_data_val = regs[bus.rdata_sel];
    rd_addr_val = regs[bus.raddr_sel];
  end
`endif

  assign bus.out_data = bus.rdata ? rd_data_val : {WIDTH{1'bz}};
  assign bus.out_addr = bus.raddr ? rd_addr_val : {WIDTH{1'bz}};
  assign bus.wrap     = wrap_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus pushes expected values into a
// scoreboard queue; a monitor on the falling edge pops and compares them.
module tb_register_file;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SEL_W = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  // kind: 0 out_data, 1 out_addr, 2 wrap, 3 err
  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb_q[$];
  int   n_tests;
  int   n_fail;

  register_file_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  register_file #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .SEL_W(SEL_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drain expectations issued this cycle and compare on the falling edge.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.kind)
          0:       act = bus.out_data;
          1:       act = bus.out_addr;
          2:       act = {7'd0, bus.wrap};
          default: act = {7'd0, bus.err};
        endcase
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic push(input int kind, input logic [7:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.rdata = 0; bus.rdata_sel = '0; bus.raddr = 0; bus.raddr_sel = '0;
    bus.wdata = 0; bus.wdata_sel = '0; bus.in_data = '0;
    bus.waddr = 0; bus.waddr_sel = '0; bus.in_addr = '0;
    bus.inc = 0; bus.dec = 0; bus.incdec_sel = '0; bus.clr_err = 0;
  endtask

  // Advance to just after the next rising edge and return to idle inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic rd_d(input logic [1:0] sel, input logic [7:0] exp, input string name);
    bus.rdata = 1; bus.rdata_sel = sel;
    push(0, exp, name);
  endtask

  task automatic rd_a(input logic [1:0] sel, input logic [7:0] exp, input string name);
    bus.raddr = 1; bus.raddr_sel = sel;
    push(1, exp, name);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    rst_n = 1'b0;
    // Reads during reset return zero.
    rd_d(2'd0, 8'h00, "reset_out_data");
    rd_a(2'd3, 8'h00, "reset_out_addr");
    push(2, 8'h00, "reset_wrap");
    push(3, 8'h00, "reset_err");
    #12 rst_n = 1'b1;

    cyc();  // write reg2 = 5A
    bus.wdata = 1; bus.wdata_sel = 2'd2; bus.in_data = 8'h5A;
    rd_d(2'd2, Bypass ? 8'h5A : 8'h00, "same_cycle_read_reg2");
    push(3, 8'h00, "err_idle");

    cyc();
    rd_d(2'd2, 8'h5A, "read_reg2");

    cyc();  // conflicting writes to reg1
    bus.wdata = 1; bus.wdata_sel = 2'd1; bus.in_data = 8'h11;
    bus.waddr = 1; bus.waddr_sel = 2'd1; bus.in_addr = 8'h22;
    rd_a(2'd1, 8'h00, "conflict_no_forward");
    push(3, 8'h00, "err_before_edge");

    cyc();
    rd_d(2'd1, 8'h00, "conflict_reg1_held");
    push(3, 8'h01, "err_set");

    cyc();
    push(3, 8'h01, "err_sticky");

    cyc();
    bus.clr_err = 1;
    push(3, 8'h01, "err_during_clr");

    cyc();
    push(3, 8'h00, "err_cleared");

    cyc();  // conflict together with clear: set wins
    bus.wdata = 1; bus.wdata_sel = 2'd0; bus.in_data = 8'h01;
    bus.waddr = 1; bus.waddr_sel = 2'd0; bus.in_addr = 8'h02;
    bus.clr_err = 1;

    cyc();
    push(3, 8'h01, "err_set_over_clr");
    bus.clr_err = 1;

    cyc();  // two non-conflicting writes
    push(3, 8'h00, "err_cleared2");
    bus.wdata = 1; bus.wdata_sel = 2'd3; bus.in_data = 8'hFF;
    bus.waddr = 1; bus.waddr_sel = 2'd0; bus.in_addr = 8'h10;
    rd_d(2'd3, Bypass ? 8'hFF : 8'h00, "fwd_data_bus");
    rd_a(2'd0, Bypass ? 8'h10 : 8'h00, "fwd_addr_bus");

    cyc();
    rd_d(2'd3, 8'hFF, "dual_write_reg3");
    rd_a(2'd0, 8'h10, "dual_write_reg0");
    bus.inc = 1; bus.incdec_sel = 2'd3;
    push(2, 8'h00, "wrap_idle");

    cyc();
    push(2, 8'h01, "wrap_inc");
    rd_d(2'd3, 8'h00, "inc_wrapped");
    bus.dec = 1; bus.incdec_sel = 2'd3;

    cyc();
    push(2, 8'h01, "wrap_dec");
    rd_d(2'd3, 8'hFF, "dec_wrapped");
    bus.inc = 1; bus.dec = 1; bus.incdec_sel = 2'd0;

    cyc();
    push(2, 8'h00, "wrap_after_pulse");
    rd_a(2'd0, 8'h10, "inc_dec_hold");
    bus.wdata = 1; bus.wdata_sel = 2'd0; bus.in_data = 8'h40;
    bus.inc = 1; bus.incdec_sel = 2'd0;

    cyc();
    push(2, 8'h00, "wrap_incdec_both");
    rd_d(2'd0, 8'h40, "write_beats_inc");
    bus.waddr = 1; bus.waddr_sel = 2'd3; bus.in_addr = 8'h07;
    bus.inc = 1; bus.incdec_sel = 2'd3;

    cyc();
    push(2, 8'h00, "wrap_suppressed_by_write");
    rd_a(2'd3, 8'h07, "addr_write_beats_inc");
    bus.inc = 1; bus.incdec_sel = 2'd2;

    cyc();
    rd_d(2'd2, 8'h5B, "inc_plain");
    bus.dec = 1; bus.incdec_sel = 2'd1;

    cyc();
    push(2, 8'h01, "wrap_dec_reg1");
    rd_d(2'd1, 8'hFF, "dec_reg1");
    rd_a(2'd2, 8'h5B, "unselected_hold");
    bus.wdata = 1; bus.wdata_sel = 2'd2; bus.in_data = 8'hAA;
    bus.waddr = 1; bus.waddr_sel = 2'd2; bus.in_addr = 8'hBB;

    cyc();  // err is now set; drop reset between edges
    #2 rst_n = 1'b0;
    rd_d(2'd3, 8'h00, "async_reset_reg3");
    rd_a(2'd0, 8'h00, "async_reset_reg0");
    push(3, 8'h00, "async_reset_err");
    push(2, 8'h00, "async_reset_wrap");
    #4 rst_n = 1'b1;

    cyc();  // first edge after reset is a normal write
    bus.wdata = 1; bus.wdata_sel = 2'd1; bus.in_data = 8'hAB;

    cyc();
    rd_d(2'd1, 8'hAB, "write_after_reset");
    rd_a(2'd2, 8'h00, "reg2_after_reset");

    cyc();
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of every register and bus.
REQ-002 SHALL have parameter DEPTH, default 4: number of registers, a power of two no smaller than 2.
REQ-003 SHALL have parameter SEL_W, default 2: select width, equal to log2(DEPTH).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports rdata, input, 1 bit, and rdata_sel, input, SEL_W bits: data-bus read enable and register select.
REQ-007 SHALL have port out_data, output, WIDTH bits: data-bus read value, driven high-Z when rdata=0.
REQ-008 SHALL have ports raddr, input, 1 bit, and raddr_sel, input, SEL_W bits: address-bus read enable and register select.
REQ-009 SHALL have port out_addr, output, WIDTH bits: address-bus read value, driven high-Z when raddr=0.
REQ-010 SHALL have ports wdata, input, 1 bit; wdata_sel, input, SEL_W bits; and in_data, input, WIDTH bits: data-bus write.
REQ-011 SHALL have ports waddr, input, 1 bit; waddr_sel, input, SEL_W bits; and in_addr, input, WIDTH bits: address-bus write.
REQ-012 SHALL have ports inc, input, 1 bit; dec, input, 1 bit; and incdec_sel, input, SEL_W bits: increment/decrement request and target register.
REQ-013 SHALL have port clr_err, input, 1 bit: clears the err flag.
REQ-014 SHALL have port wrap, output, 1 bit: registered one-cycle pulse raised when an inc/dec wraps.
REQ-015 SHALL have port err, output, 1 bit: sticky registered write-conflict flag.

Function
REQ-016 Reads SHALL be combinational: out_data = reg[rdata_sel] when rdata=1, out_addr = reg[raddr_sel] when raddr=1; both ports may select the same register at once.
REQ-017 wdata=1 SHALL load in_data into reg[wdata_sel] at the clock edge.
REQ-018 waddr=1 SHALL load in_addr into reg[waddr_sel] at the clock edge.
REQ-019 When wdata=1, waddr=1 and wdata_sel==waddr_sel, that register SHALL hold its value and err SHALL be set at the edge.
REQ-020 When wdata=1, waddr=1 and the selects differ, both writes SHALL complete in the same cycle.
REQ-021 inc=1 with dec=0 SHALL set reg[incdec_sel] to reg+1 modulo 2^WIDTH.
REQ-022 dec=1 with inc=0 SHALL set reg[incdec_sel] to reg-1 modulo 2^WIDTH.
REQ-023 inc=1 and dec=1 together SHALL leave the register unchanged and assert no wrap.
REQ-024 wrap SHALL be 1 for exactly the cycle after an inc from all-ones or a dec from zero, and 0 otherwise.
REQ-025 A write (data or address bus) to the register selected by incdec_sel SHALL take priority over inc/dec: the inc/dec is dropped and wrap is not asserted.
REQ-026 Once set, err SHALL hold until clr_err=1.
REQ-027 A conflict in the same cycle as clr_err=1 SHALL set err, since set wins over clear.
REQ-028 Unselected registers SHALL hold their value every cycle.

Reset
REQ-029 While rst_n=0, all registers SHALL be 0, wrap SHALL be 0 and err SHALL be 0, immediately and without waiting for clk.
REQ-030 Assertion of rst_n mid-write or mid-increment SHALL abort the operation; the reset value wins.
REQ-031 The first clock edge after rst_n rises SHALL perform normal operation.
REQ-032 out_data and out_addr SHALL follow rdata and raddr during reset, reading 0 when enabled.

Configuration
REQ-033 With macro REGFILE_BYPASS_EN defined, a read whose select matches an active non-conflicting write in the same cycle SHALL return the write value combinationally; when both buses write different registers, each is forwarded to matching readers.
REQ-034 Without REGFILE_BYPASS_EN, reads SHALL always return the stored value, with the new value visible from the cycle after the edge.

Verification
REQ-035 Scenario: reset, then wdata=1, wdata_sel=2, in_data=0x5A; next cycle rdata=1, rdata_sel=2 -> out_data=0x5A; raddr=0 -> out_addr=Z.
REQ-036 Scenario: wdata=1, waddr=1, both selecting reg 1 with in_data=0x11 and in_addr=0x22 -> reg1 unchanged, err=1; err=1 persists until clr_err pulse, then err=0.
REQ-037 Scenario: reg3=0xFF, inc=1, incdec_sel=3 -> reg3=0x00 and wrap=1 for one cycle; dec on reg3=0x00 -> 0xFF and wrap=1.
REQ-038 Scenario: inc=1, dec=1 on reg0=0x10 -> reg0 stays 0x10, wrap=0; wdata to reg0 (0x40) with inc on reg0 -> reg0=0x40.
REQ-039 Scenario: with REGFILE_BYPASS_EN, wdata to reg2 (0x33) while rdata_sel=2 -> out_data=0x33 in the same cycle; without the macro -> old value, 0x33 next cycle.
REQ-040 Scenario: drop rst_n between clock edges after loading values -> all registers read 0 and err=0 before the next edge.
